// File: rtl/buttom_debounce_pkg.sv
// Shared debounce/repeat defaults for this block and the bus button peripheral.
// Also holds the per-bit output bundle and a counter-width helper.
package buttom_debounce_pkg;

    localparam int BUTTOM_DEB_CYCLES    = 50000;
    localparam int BUTTOM_REPEAT_CYCLES = 25000000;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic flag;
    } cell_out_t;

    // Bits needed to count from 0 up to n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buttom_debounce_cell.sv
// Single-bit conditioner: polarity, 2-flop sync, stability counter, pulses, sticky flag.
// Optional auto-repeat counter when BUTTOM_AUTOREPEAT_EN is defined.
module buttom_debounce_cell
    import buttom_debounce_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = BUTTOM_DEB_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_CYCLES   = BUTTOM_REPEAT_CYCLES
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      raw_i,
    input  logic      clr_i,
    output cell_out_t out_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 norm_s;
    logic                 s1_q, s2_q;
    logic                 stable_q, stable_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 press_q, press_d;
    logic                 rel_q, rel_d;
    logic                 flag_q, flag_d;
    logic                 accept_s, rise_s, fall_s;
    logic                 rep_fire_s;

    assign norm_s = (ACTIVE_LOW != 0) ? ~raw_i : raw_i;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept_s = 1'b1;
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        rise_s  = accept_s & s2_q;
        fall_s  = accept_s & ~s2_q;
        press_d = rise_s | rep_fire_s;
        rel_d   = fall_s;
        // A new press on the same edge as a clear keeps the flag set.
        flag_d  = press_d | (flag_q & ~clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            s1_q     <= norm_s;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            flag_q   <= flag_d;
        end
    end

`ifdef BUTTOM_AUTOREPEAT_EN
    localparam int               REP_W    = cnt_w(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_q, rep_d;

    // Repeat is suppressed on the edge a release is accepted so pulses never overlap.
    always_comb begin
        rep_fire_s = stable_q & ~fall_s & (rep_q == REP_LAST);
        if (!stable_q || rise_s || rep_fire_s) begin
            rep_d = '0;
        end else begin
            rep_d = rep_q + REP_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    assign out_o = '{level: stable_q, press: press_q, rel: rel_q, flag: flag_q};

endmodule

// File: rtl/buttom_debounce.sv
// Debounced button/DIP front end: BUTTOM_NUM independent buttom_debounce_cell instances.
// Define BUTTOM_AUTOREPEAT_EN to add per-bit auto-repeat press pulses.
module buttom_debounce
    import buttom_debounce_pkg::*;
#(
    parameter int BUTTOM_NUM      = 4,
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = BUTTOM_DEB_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_CYCLES   = BUTTOM_REPEAT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUTTOM_NUM-1:0] buttom_raw,
    input  logic [BUTTOM_NUM-1:0] event_clr,
    output logic [BUTTOM_NUM-1:0] buttom_level,
    output logic [BUTTOM_NUM-1:0] press_pulse,
    output logic [BUTTOM_NUM-1:0] release_pulse,
    output logic [BUTTOM_NUM-1:0] press_flag
);

    localparam longint DEB_MAX = (64'sd1 <<< CNT_WIDTH) - 64'sd1;

    if ((DEBOUNCE_CYCLES < 1) || (longint'(DEBOUNCE_CYCLES) > DEB_MAX)) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must lie in 1 .. 2**CNT_WIDTH-1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rep
        $error("REPEAT_CYCLES must be at least 1");
    end

    for (genvar g = 0; g < BUTTOM_NUM; g++) begin : g_cell
        cell_out_t out_s;

        buttom_debounce_cell #(
            .CNT_WIDTH      (CNT_WIDTH),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_cell (
            .clk_i(clk),
            .rst_i(rst),
            .raw_i(buttom_raw[g]),
            .clr_i(event_clr[g]),
            .out_o(out_s)
        );

        assign buttom_level[g]  = out_s.level;
        assign press_pulse[g]   = out_s.press;
        assign release_pulse[g] = out_s.rel;
        assign press_flag[g]    = out_s.flag;
    end

endmodule
